run_monitor: RTL
================

Name: run_monitor

Overview:
Synthesizable run-control and watchdog block for multi-CPU builds of the 8-bit machine. Sequences the CPU reset pulse, gates each run's clock enable, records the cycle at which each channel halts, and ends the run on all-halted, timeout or abort. Sits between the top-level clock/reset and one or more machine instances. Gives benches and FPGA builds one completion/timeout mechanism in place of ad-hoc delays.

Parameters:
NUM_CH, 1, number of monitored CPU channels (1..16)
CNT_W, 16, width of cycle counter and captured halt cycles
RESET_CYCLES, 2, cycles cpu_reset is held high per run (>=1)
TIMEOUT_CYCLES, 2000, enabled cycles before timeout (1..2^CNT_W-1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
start  in  1  begin a run (sampled in IDLE/DONE/TIMEOUT only)
abort  in  1  terminate the current run
step  in  1  single-step request (used only with RUN_MONITOR_STEP_EN)
halted  in  NUM_CH  per-channel CPU halted flag
cpu_reset  out  1  active-high reset to the machines
cpu_en  out  1  clock enable to the machines
busy  out  1  high in RST_HOLD or RUN
done  out  1  all channels halted (sticky until next start/reset)
timed_out  out  1  watchdog expired (sticky until next start/reset)
halt_mask  out  NUM_CH  channels that halted this run
cycle_count  out  CNT_W  enabled cycles elapsed this run
rd_sel  in  max(1,$clog2(NUM_CH))  halt-cycle readout select
rd_cycle  out  CNT_W  captured halt cycle of channel rd_sel (combinational read)

Behaviour:
- Reset (reset==0 at posedge): state IDLE; all outputs 0; captured cycles 0.
- States: IDLE, RST_HOLD, RUN, DONE, TIMEOUT.
- IDLE/DONE/TIMEOUT + start: go to RST_HOLD next cycle; clear done, timed_out, halt_mask, cycle_count, captured cycles.
- RST_HOLD: cpu_reset=1, cpu_en=0 for exactly RESET_CYCLES cycles, then RUN. halted ignored.
- RUN: cpu_en=1 (see optional feature). cycle_count increments by 1 on every enabled cycle.
- Halt capture in RUN: halted[i]==1 and halt_mask[i]==0 -> halt_mask[i]<=1, cycle[i]<=current cycle_count. Later changes on halted[i] ignored. Only the first capture per channel per run is kept.
- Completion: if (halt_mask | halted) is all ones in a RUN cycle -> DONE next cycle; done=1, cpu_en=0.
- Timeout: cycle_count==TIMEOUT_CYCLES and not all halted -> TIMEOUT; timed_out=1, cpu_en=0.
- Completion and timeout in the same cycle: completion wins; timed_out stays 0.
- cycle_count never wraps: it stops at TIMEOUT_CYCLES.
- abort in RST_HOLD or RUN: IDLE next cycle; cpu_en=0, cpu_reset=0. done/timed_out stay 0. halt_mask, cycle_count and captured cycles are retained.
- abort and start in the same cycle: abort wins.
- start while busy: ignored.
- reset mid-run: same result as power-on reset, including cpu_en=0 immediately.
- rd_sel >= NUM_CH: rd_cycle=0.
- All outputs are registered except rd_cycle.

Optional Feature:
RUN_MONITOR_STEP_EN
- Defined: in RUN, cpu_en = step (one enabled cycle per step-high cycle). cycle_count, timeout and halt capture advance only on enabled cycles. A halted[] change seen on a non-enabled cycle is captured on the next enabled cycle.
- Undefined: step is ignored; cpu_en=1 throughout RUN.

Test Plan:
- Reset: drive reset low 2 cycles, then high -> all outputs 0, state IDLE; start pulse -> cpu_reset high exactly 2 cycles, then cpu_en high.
- NUM_CH=1, TIMEOUT_CYCLES=20: halted rises at cycle_count 7 -> halt_mask=1, rd_cycle=7, done=1 next cycle, cpu_en=0, timed_out=0.
- NUM_CH=3: halts at counts 4, 9, 15 -> done after the third halt. rd_sel=0/1/2 reads 4/9/15; rd_sel=3 reads 0.
- TIMEOUT_CYCLES=20, no halts -> cycle_count=20, timed_out=1, done=0, halt_mask=0. Last channel halting at count 20 -> done=1, timed_out=0.
- abort at cycle_count 5 -> IDLE next cycle, busy=0, done=timed_out=0, cycle_count holds 5. New start clears everything and runs normally.
- Built with RUN_MONITOR_STEP_EN, step pulsed 3 times over 10 cycles -> cycle_count=3 and cpu_en high exactly 3 cycles.

Source files
------------

// File: rtl/run_monitor.sv
// rtl/run_monitor.sv - run sequencer and watchdog for multi-CPU 8-bit machine builds
// Define RUN_MONITOR_STEP_EN to drive cpu_en from step while in RUN.
module run_monitor #(
  parameter int NUM_CH         = 1,
  parameter int CNT_W          = 16,
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 2000,
  localparam int SEL_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              step,
  input  logic [NUM_CH-1:0] halted,
  output logic              cpu_reset,
  output logic              cpu_en,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [NUM_CH-1:0] halt_mask,
  output logic [CNT_W-1:0]  cycle_count,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_cycle
);

  localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

`ifdef RUN_MONITOR_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_RST_HOLD, S_RUN, S_DONE, S_TIMEOUT
  } state_e;

  state_e             state_q, state_d;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               cpu_en_q, cpu_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timed_out_q, timed_out_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   cap_q [NUM_CH];
  logic [CNT_W-1:0]   cap_d [NUM_CH];
  logic               run_en;

  // cpu_en_q marks an enabled cycle; all RUN bookkeeping keys off it
  assign run_en = STEP_EN ? step : 1'b1;

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    cpu_reset_d = 1'b0;
    cpu_en_d    = 1'b0;
    done_d      = done_q;
    timed_out_d = timed_out_q;
    mask_d      = mask_q;
    count_d     = count_q;
    cap_d       = cap_q;
    case (state_q)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (start && !abort) begin
          state_d     = S_RST_HOLD;
          rst_cnt_d   = '0;
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
          timed_out_d = 1'b0;
          mask_d      = '0;
          count_d     = '0;
          for (int i = 0; i < NUM_CH; i++) cap_d[i] = '0;
        end
      end
      S_RST_HOLD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (rst_cnt_q == RST_W'(RESET_CYCLES - 1)) begin
          state_d  = S_RUN;
          cpu_en_d = run_en;
        end else begin
          rst_cnt_d   = rst_cnt_q + 1'b1;
          cpu_reset_d = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cpu_en_d = run_en;
          if (cpu_en_q) begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (halted[i] && !mask_q[i]) cap_d[i] = count_q;
            end
            mask_d = mask_q | halted;
            if (count_q != TMO) count_d = count_q + 1'b1;
            // completion is tested first so it wins over a same-cycle timeout
            if (&(mask_q | halted)) begin
              state_d  = S_DONE;
              done_d   = 1'b1;
              cpu_en_d = 1'b0;
            end else if (count_q == TMO) begin
              state_d     = S_TIMEOUT;
              timed_out_d = 1'b1;
              cpu_en_d    = 1'b0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RST_HOLD) || (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= '0;
      cpu_reset_q <= 1'b0;
      cpu_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      mask_q      <= '0;
      count_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) cap_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cpu_reset_q <= cpu_reset_d;
      cpu_en_q    <= cpu_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timed_out_q <= timed_out_d;
      mask_q      <= mask_d;
      count_q     <= count_d;
      cap_q       <= cap_d;
    end
  end

  always_comb begin
    rd_cycle = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) rd_cycle = cap_q[i];
    end
  end

  assign cpu_reset   = cpu_reset_q;
  assign cpu_en      = cpu_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timed_out   = timed_out_q;
  assign halt_mask   = mask_q;
  assign cycle_count = count_q;

endmodule
